attribute_list_parser: RTL and testbench

- Parametrised successor to the single-attribute parser.
- Consumes the character stream after a tag name and parses every `name=value` pair up to the closing `>` or `/`.
- Emits one record (type, value, flags) per recognised attribute.
- Sits between the tag parser and the element/style builder.
- Supports decimal values, `#`-prefixed hex values, quoted or bare values, and saturating overflow.

---
 rtl/attribute_list_parser.sv | 265 ++++++++++++++++++++++++++
 tb/tb_attribute_list_parser.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/attribute_list_parser.sv
// Parses the name=value attribute list that follows a tag name and emits one typed record per attribute.
// Optional build macro ATTR_PERCENT_EN adds att_is_percent for a trailing '%' on decimal values.
module attribute_list_parser #(
  parameter int VAL_WIDTH  = 16,
  parameter int MAX_DIGITS = 6,
  parameter int TYPE_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [7:0]            char,
  input  logic                  char_valid,
  output logic                  next_char,
  output logic                  att_valid,
  output logic [TYPE_WIDTH-1:0] att_type,
  output logic [VAL_WIDTH-1:0]  att_value,
  output logic                  att_is_hex,
  output logic                  att_overflow,
  output logic                  has_finished
`ifdef ATTR_PERCENT_EN
  ,
  output logic                  att_is_percent
`endif
);

  localparam logic [TYPE_WIDTH-1:0] ATT_NONE     = 0;
  localparam logic [TYPE_WIDTH-1:0] ATT_COLOR    = 1;
  localparam logic [TYPE_WIDTH-1:0] ATT_SIZE     = 2;
  localparam logic [TYPE_WIDTH-1:0] ATT_SRC      = 3;
  localparam logic [TYPE_WIDTH-1:0] ATT_WIDTH    = 4;
  localparam logic [TYPE_WIDTH-1:0] ATT_HEIGHT   = 5;
  localparam logic [TYPE_WIDTH-1:0] ATT_HREF     = 6;
  localparam logic [TYPE_WIDTH-1:0] ATT_BG       = 7;
  localparam logic [TYPE_WIDTH-1:0] ATT_BORDER   = 8;
  localparam logic [TYPE_WIDTH-1:0] ATT_PADDING  = 9;
  localparam logic [TYPE_WIDTH-1:0] ATT_POSITION = 10;
  localparam logic [TYPE_WIDTH-1:0] ATT_MARGIN   = 11;

  localparam int W2 = VAL_WIDTH + 5;
  localparam int NW = $clog2(MAX_DIGITS + 1);

  typedef enum logic [2:0] {
    S_SKIP_WS, S_NAME, S_VALUE_OPEN, S_VALUE, S_EMIT, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            c0_q, c0_d, c1_q, c1_d, quote_q, quote_d;
  logic [TYPE_WIDTH-1:0] type_q, type_d;
  logic [VAL_WIDTH-1:0]  acc_q, acc_d;
  logic [NW-1:0]         ndig_q, ndig_d;
  logic                  hex_q, hex_d, ovf_q, ovf_d;
  logic [TYPE_WIDTH-1:0] att_type_q, att_type_d;
  logic [VAL_WIDTH-1:0]  att_value_q, att_value_d;
  logic                  att_hex_q, att_hex_d, att_ovf_q, att_ovf_d;
  logic                  done_q, done_d;
`ifdef ATTR_PERCENT_EN
  logic                  pct_q, pct_d, att_pct_q, att_pct_d;
`endif

  // Character classes of the current input
  logic       is_ws, is_term, is_letter, is_quote, is_dec, is_hexd, is_digit;
  logic [7:0] lc;
  logic [3:0] dig;
  logic [W2-1:0] wide;
  logic       consume;

  // First two name letters pick the attribute; bgcolor and background both map to BG.
  function automatic logic [TYPE_WIDTH-1:0] classify(input logic [7:0] a, input logic [7:0] b);
    logic [TYPE_WIDTH-1:0] t;
    t = ATT_NONE;
    case (a)
      "c": t = ATT_COLOR;
      "s": t = (b == "i") ? ATT_SIZE : (b == "r") ? ATT_SRC : ATT_NONE;
      "w": t = ATT_WIDTH;
      "h": t = (b == "e") ? ATT_HEIGHT : (b == "r") ? ATT_HREF : ATT_NONE;
      "b": t = (b == "a" || b == "g") ? ATT_BG : (b == "o") ? ATT_BORDER : ATT_NONE;
      "p": t = (b == "a") ? ATT_PADDING : (b == "o") ? ATT_POSITION : ATT_NONE;
      "m": t = ATT_MARGIN;
      default: t = ATT_NONE;
    endcase
    return t;
  endfunction

  always_comb begin
    is_ws     = (char == 8'h20) || (char == 8'h09) || (char == 8'h0d) || (char == 8'h0a);
    is_term   = (char == ">") || (char == "/");
    lc        = (char inside {[8'h41:8'h5a]}) ? (char | 8'h20) : char;
    is_letter = lc inside {[8'h61:8'h7a]};
    is_quote  = (char == 8'h22) || (char == 8'h27);
    is_dec    = char inside {[8'h30:8'h39]};
    is_hexd   = is_dec || (lc inside {[8'h61:8'h66]});
    is_digit  = hex_q ? is_hexd : is_dec;
    // '0'..'9' carry their value in the low nibble; a-f/A-F have low nibble 1..6.
    dig       = is_dec ? char[3:0] : (char[3:0] + 4'd9);
    wide      = hex_q ? {1'b0, acc_q, 4'd0} : (W2'(acc_q) * W2'(10));
    wide      = wide + W2'(dig);
  end

  always_comb begin
    state_d     = state_q;
    c0_d        = c0_q;
    c1_d        = c1_q;
    quote_d     = quote_q;
    type_d      = type_q;
    acc_d       = acc_q;
    ndig_d      = ndig_q;
    hex_d       = hex_q;
    ovf_d       = ovf_q;
    att_type_d  = att_type_q;
    att_value_d = att_value_q;
    att_hex_d   = att_hex_q;
    att_ovf_d   = att_ovf_q;
    done_d      = done_q;
`ifdef ATTR_PERCENT_EN
    pct_d       = pct_q;
    att_pct_d   = att_pct_q;
`endif
    consume     = 1'b0;

    if (enable) begin
      case (state_q)
        S_SKIP_WS: if (char_valid) begin
          consume = 1'b1;
          if (is_term) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if (is_letter) begin
            c0_d    = lc;
            c1_d    = 8'd0;
            state_d = S_NAME;
          end
        end
        S_NAME: if (char_valid) begin
          if (is_letter) begin
            consume = 1'b1;
            if (c1_q == 8'd0) c1_d = lc;
          end else if (char == "=") begin
            consume = 1'b1;
            type_d  = classify(c0_q, c1_q);
            state_d = S_VALUE_OPEN;
          end else if (is_ws || is_term) begin
            state_d = S_SKIP_WS;
          end else begin
            consume = 1'b1;
          end
        end
        S_VALUE_OPEN: if (char_valid) begin
          if (is_quote && quote_q == 8'd0 && !hex_q) begin
            consume = 1'b1;
            quote_d = char;
          end else if (char == "#" && !hex_q) begin
            consume = 1'b1;
            hex_d   = 1'b1;
          end else begin
            state_d = S_VALUE;
          end
        end
        S_VALUE: if (char_valid) begin
          if (is_digit) begin
            consume = 1'b1;
            if (ndig_q == NW'(MAX_DIGITS)) begin
              ovf_d = 1'b1;
            end else begin
              ndig_d = ndig_q + 1'b1;
              if (wide[W2-1:VAL_WIDTH] != '0) begin
                acc_d = '1;
                ovf_d = 1'b1;
              end else begin
                acc_d = wide[VAL_WIDTH-1:0];
              end
            end
`ifdef ATTR_PERCENT_EN
          end else if (char == "%" && !hex_q && ndig_q != '0 && !pct_q) begin
            consume = 1'b1;
            pct_d   = 1'b1;
`endif
          end else if (quote_q != 8'd0 && char != quote_q) begin
            consume = 1'b1;
          end else begin
            // Closing quote is eaten; an unquoted terminator is left for SKIP_WS.
            consume = (quote_q != 8'd0);
            state_d = S_EMIT;
            if (type_q != ATT_NONE) begin
              att_type_d  = type_q;
              att_value_d = acc_q;
              att_hex_d   = hex_q;
              att_ovf_d   = ovf_q;
`ifdef ATTR_PERCENT_EN
              att_pct_d   = pct_q;
`endif
            end
          end
        end
        S_EMIT: begin
          state_d = S_SKIP_WS;
          acc_d   = '0;
          ndig_d  = '0;
          hex_d   = 1'b0;
          ovf_d   = 1'b0;
          quote_d = 8'd0;
          type_d  = ATT_NONE;
`ifdef ATTR_PERCENT_EN
          pct_d   = 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_SKIP_WS;
      c0_q        <= 8'd0;
      c1_q        <= 8'd0;
      quote_q     <= 8'd0;
      type_q      <= ATT_NONE;
      acc_q       <= '0;
      ndig_q      <= '0;
      hex_q       <= 1'b0;
      ovf_q       <= 1'b0;
      att_type_q  <= ATT_NONE;
      att_value_q <= '0;
      att_hex_q   <= 1'b0;
      att_ovf_q   <= 1'b0;
      done_q      <= 1'b0;
`ifdef ATTR_PERCENT_EN
      pct_q       <= 1'b0;
      att_pct_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      c0_q        <= c0_d;
      c1_q        <= c1_d;
      quote_q     <= quote_d;
      type_q      <= type_d;
      acc_q       <= acc_d;
      ndig_q      <= ndig_d;
      hex_q       <= hex_d;
      ovf_q       <= ovf_d;
      att_type_q  <= att_type_d;
      att_value_q <= att_value_d;
      att_hex_q   <= att_hex_d;
      att_ovf_q   <= att_ovf_d;
      done_q      <= done_d;
`ifdef ATTR_PERCENT_EN
      pct_q       <= pct_d;
      att_pct_q   <= att_pct_d;
`endif
    end
  end

  // Pulse is gated by enable so a frozen EMIT holds the record back until enable returns.
  assign next_char    = consume;
  assign att_valid    = (state_q == S_EMIT) && enable && (type_q != ATT_NONE);
  assign att_type     = att_type_q;
  assign att_value    = att_value_q;
  assign att_is_hex   = att_hex_q;
  assign att_overflow = att_ovf_q;
  assign has_finished = done_q;
`ifdef ATTR_PERCENT_EN
  assign att_is_percent = att_pct_q;
`endif

endmodule

// File: tb/tb_attribute_list_parser.sv
// Scoreboard bench for attribute_list_parser: a 16-bit and a 24-bit instance share one character stream.
module tb_attribute_list_parser;

  localparam logic [3:0] ATT_COLOR = 1, ATT_SIZE = 2, ATT_SRC = 3, ATT_WIDTH = 4,
    ATT_HEIGHT = 5, ATT_HREF = 6, ATT_BG = 7, ATT_BORDER = 8, ATT_PADDING = 9,
    ATT_POSITION = 10, ATT_MARGIN = 11;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic [7:0]  char = 8'd0;
  logic        char_valid = 1'b0;

  logic        next_char, att_valid, att_is_hex, att_overflow, has_finished;
  logic [3:0]  att_type;
  logic [15:0] att_value;
  logic        w_next_char, w_att_valid, w_att_is_hex, w_att_overflow, w_has_finished;
  logic [3:0]  w_att_type;
  logic [23:0] w_att_value;
  logic        pct, w_pct;

  // record = {type[3:0], value[23:0], hex, overflow, percent}
  logic [30:0] exp_q[$];
  logic [30:0] exp_w_q[$];

  int vectors = 0;
  int miscompares = 0;

  attribute_list_parser #(.VAL_WIDTH(16), .MAX_DIGITS(6), .TYPE_WIDTH(4)) u_dut (
    .clock(clock), .reset(reset), .enable(enable), .char(char), .char_valid(char_valid),
    .next_char(next_char), .att_valid(att_valid), .att_type(att_type), .att_value(att_value),
    .att_is_hex(att_is_hex), .att_overflow(att_overflow), .has_finished(has_finished)
`ifdef ATTR_PERCENT_EN
    , .att_is_percent(pct)
`endif
  );

  attribute_list_parser #(.VAL_WIDTH(24), .MAX_DIGITS(6), .TYPE_WIDTH(4)) u_wide (
    .clock(clock), .reset(reset), .enable(enable), .char(char), .char_valid(char_valid),
    .next_char(w_next_char), .att_valid(w_att_valid), .att_type(w_att_type), .att_value(w_att_value),
    .att_is_hex(w_att_is_hex), .att_overflow(w_att_overflow), .has_finished(w_has_finished)
`ifdef ATTR_PERCENT_EN
    , .att_is_percent(w_pct)
`endif
  );

`ifndef ATTR_PERCENT_EN
  assign pct   = 1'b0;
  assign w_pct = 1'b0;
`endif

  // clock / reset
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [30:0] rec(input logic [3:0] t, input logic [23:0] v,
                                      input logic h, input logic o, input logic p);
    return {t, v, h, o, p};
  endfunction

  task automatic expect2(input logic [30:0] r16, input logic [30:0] r24);
    exp_q.push_back(r16);
    exp_w_q.push_back(r24);
  endtask

  // scoreboard: pop and compare whenever a record pulses
  always @(negedge clock) begin
    if (!reset) begin
      if (att_valid) begin
        if (exp_q.size() == 0) check("unexpected_rec16", 32'(att_type), 32'hffff_ffff);
        else check("rec16", {1'b0, att_type, 8'h00, att_value, att_is_hex, att_overflow, pct},
                   {1'b0, exp_q.pop_front()});
      end
      if (w_att_valid) begin
        if (exp_w_q.size() == 0) check("unexpected_rec24", 32'(w_att_type), 32'hffff_ffff);
        else check("rec24", {1'b0, w_att_type, w_att_value, w_att_is_hex, w_att_overflow, w_pct},
                   {1'b0, exp_w_q.pop_front()});
      end
    end
  end

  task automatic do_reset();
    @(posedge clock); #2;
    reset = 1'b1;
    char_valid = 1'b0;
    enable = 1'b1;
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
  endtask

  // drives a string one char at a time, advancing only when next_char is seen
  task automatic send(input string s, input bit rnd);
    int i;
    int budget;
    i = 0;
    budget = 0;
    while (i < s.len()) begin
      @(posedge clock); #2;
      char       = s[i];
      char_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      enable     = rnd ? ($urandom_range(0, 4) != 0) : 1'b1;
      #4;
      if (next_char) begin
        i++;
        budget = 0;
      end else begin
        budget++;
        if (budget > 60) begin
          check("stall", 32'(i), 32'(s.len()));
          i = s.len();
        end
      end
    end
    @(posedge clock); #2;
    char_valid = 1'b0;
    enable = 1'b1;
    repeat (6) @(posedge clock);
    #2;
  endtask

  task automatic drain_check(input string tag);
    check({tag, "_left16"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_left24"}, 32'(exp_w_q.size()), 32'd0);
  endtask

  initial begin
    do_reset();
    #1;
    check("rst_rec", {1'b0, att_type, 8'h00, att_value, att_is_hex, att_overflow, pct}, 32'd0);
    check("rst_valid", 32'(att_valid), 32'd0);
    check("rst_finished", 32'(has_finished), 32'd0);
    check("rst_next_char", 32'(next_char), 32'd0);

    // plain quoted decimal, then terminator holds parser in DONE
    expect2(rec(ATT_WIDTH, 120, 0, 0, 0), rec(ATT_WIDTH, 120, 0, 0, 0));
    send(" width=\"120\">", 1'b0);
    drain_check("s1");
    check("s1_finished", 32'(has_finished), 32'd1);
    char = "a";
    char_valid = 1'b1;
    repeat (3) begin
      #1 check("s1_done_no_consume", 32'(next_char), 32'd0);
      @(posedge clock); #2;
    end
    char_valid = 1'b0;

    // hex saturation at 16 bits, fits at 24 bits
    do_reset();
    expect2(rec(ATT_BG, 24'hffff, 1, 1, 0), rec(ATT_BG, 24'hff8000, 1, 0, 0));
    expect2(rec(ATT_HEIGHT, 30, 0, 0, 0), rec(ATT_HEIGHT, 30, 0, 0, 0));
    send("bgcolor=#FF8000 height=30/", 1'b0);
    drain_check("s2");
    check("s2_finished", 32'(has_finished), 32'd1);

    // unknown attribute is parsed but never emitted
    do_reset();
    expect2(rec(ATT_MARGIN, 5, 0, 0, 0), rec(ATT_MARGIN, 5, 0, 0, 0));
    send("foo=\"7\" margin='5'>", 1'b0);
    drain_check("s3");
    check("s3_hold", {1'b0, att_type, 8'h00, att_value, att_is_hex, att_overflow, pct},
          {1'b0, rec(ATT_MARGIN, 5, 0, 0, 0)});

    // digit limit
    do_reset();
    expect2(rec(ATT_SIZE, 65535, 0, 1, 0), rec(ATT_SIZE, 999999, 0, 1, 0));
    send("size=9999999>", 1'b0);
    drain_check("s4");

    // reset arriving mid-value
    do_reset();
    expect2(rec(ATT_WIDTH, 7, 0, 0, 0), rec(ATT_WIDTH, 7, 0, 0, 0));
    send(" width=\"7\" height=\"12", 1'b0);
    drain_check("s5a");
    @(negedge clock); #1;
    reset = 1'b1;
    #1;
    check("async_rst_rec", {1'b0, att_type, 8'h00, att_value, att_is_hex, att_overflow, pct}, 32'd0);
    check("async_rst_rec24", {1'b0, w_att_type, w_att_value, w_att_is_hex, w_att_overflow, w_pct}, 32'd0);
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
    expect2(rec(ATT_SRC, 4, 0, 0, 0), rec(ATT_SRC, 4, 0, 0, 0));
    send(" src=4>", 1'b0);
    drain_check("s5b");

    // boundaries: valueless name, exact max, one past max, empty value
    do_reset();
    expect2(rec(ATT_BORDER, 65535, 0, 0, 0), rec(ATT_BORDER, 65535, 0, 0, 0));
    expect2(rec(ATT_POSITION, 65535, 0, 1, 0), rec(ATT_POSITION, 65536, 0, 0, 0));
    expect2(rec(ATT_HREF, 0, 0, 0, 0), rec(ATT_HREF, 0, 0, 0, 0));
    send(" checked border=65535 position=65536 href=\"\">", 1'b0);
    drain_check("s6");
    check("s6_finished", 32'(has_finished), 32'd1);

    // random char_valid / enable throttling over a mixed stream
    for (int r = 0; r < 4; r++) begin
      do_reset();
      expect2(rec(ATT_WIDTH, 120, 0, 0, 0), rec(ATT_WIDTH, 120, 0, 0, 0));
      expect2(rec(ATT_COLOR, 24'h1a2, 1, 0, 0), rec(ATT_COLOR, 24'h1a2, 1, 0, 0));
      expect2(rec(ATT_PADDING, 0, 0, 0, 0), rec(ATT_PADDING, 0, 0, 0, 0));
      send(" width=\"120\" color=#1a2 padding=0>", 1'b1);
      drain_check("rnd_mix");
    end

    // trailing percent, throttled
    for (int r = 0; r < 3; r++) begin
      do_reset();
`ifdef ATTR_PERCENT_EN
      expect2(rec(ATT_WIDTH, 50, 0, 0, 1), rec(ATT_WIDTH, 50, 0, 0, 1));
`else
      expect2(rec(ATT_WIDTH, 50, 0, 0, 0), rec(ATT_WIDTH, 50, 0, 0, 0));
`endif
      send("width=\"50%\">", (r != 0));
      drain_check("pct");
      check("pct_finished", 32'(has_finished), 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
